min_index_codec: RTL and testbench
==================================

Name: min_index_codec

Overview:
- Paired lowest-set-bit priority encoder ("minimum") and its inverse one-hot decoder ("minimum_inverse"), both parameterised by index width N.
- Maps a 2^N-bit request/valid vector to the index of its lowest set bit, and maps an index back to a one-hot vector.
- Used by allocation, arbitration and replacement logic (way/slot selection).
- Both results are registered: one clock of latency.

Parameters:
- N, default 3: index width. Vector width is W = 2^N. Legal range 1..6.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- enc_in  input  W  vector to encode; bit 0 has the highest priority.
- enc_out  output  N  registered index of the lowest set bit of enc_in.
- enc_none  output  1  registered flag, 1 when enc_in was all zeros.
- dec_in  input  N  index to decode.
- dec_out  output  W  registered one-hot vector, bit dec_in set.

Behaviour:
- Reset values: enc_out = 0, enc_none = 1, dec_out = 0. Reset is sampled on the clock edge only.
- Encoder, combinational core:
  - idx = smallest i such that enc_in[i] == 1.
  - All other set bits are ignored.
  - All-zero input: idx = 0, none = 1. Otherwise none = 0.
- Decoder, combinational core:
  - onehot = 1 << dec_in, exactly one bit set, width W.
  - Every N-bit value is legal, so there is no out-of-range case.
- Registration:
  - On each rising clk edge with reset = 0: enc_out <= idx, enc_none <= none, dec_out <= onehot.
  - Latency is exactly 1 cycle from inputs to outputs. Throughput is one new input per cycle. No handshake and no stall.
- Reset asserted mid-stream:
  - Outputs take reset values on that edge, regardless of inputs.
  - The first post-reset edge reflects the inputs present at that edge.
- Inverse property:
  - For every k in 0..W-1, encoding decode(k) yields k with enc_none = 0.
  - For every nonzero v, decode(encode(v)) equals the lowest-set-bit isolation of v, i.e. v & -v.
- Width rules:
  - Indices are unsigned N-bit values.
  - The encoder must be synthesisable as a log-depth tree or an equivalent priority loop. No latches.
  - Outputs must be X-free whenever inputs are known.
- Encoder and decoder paths are fully independent. Simultaneous changes on both inputs do not interact.

Decomposition:
- Shared package min_codec_pkg:
  - default N;
  - function clog2-style helper;
  - typedef for the index type and the W-bit vector type.
- One natural sub-module: lsb_priority_encoder.
  - Combinational, parameter N.
  - Ports vec[W], idx[N], none.
- The decoder is a single shift expression inside min_index_codec. Output registers live in min_index_codec.

Test Plan (N = 3 unless stated):
- Reset held 2 cycles, then released with enc_in = 8'h00 → enc_out = 0, enc_none = 1, dec_out = 8'h00 during reset; after the first edge, enc_out = 0, enc_none = 1.
- enc_in = 8'b1010_0000 → enc_out = 5, enc_none = 0 one cycle later. Then enc_in = 8'h80 → 7. Then 8'hFF → 0.
- Sweep enc_in 0..255, one value per cycle → each output equals the lowest-set-bit index of the input from the previous cycle, checked against a reference model; 0 gives enc_none = 1.
- Sweep dec_in 0..7 → dec_out = 8'h01, 02, 04, 08, 10, 20, 40, 80, each one cycle later.
- Round trip: feed dec_out back to enc_in for all k → enc_out = k two cycles after dec_in = k. Repeat with N = 1 and N = 5 (e.g. dec_in = 17 → 32'h0002_0000 → 17).
- Reset asserted mid-sweep with enc_in = 8'h40, dec_in = 6 → the next edge gives enc_out = 0, enc_none = 1, dec_out = 0. After release → enc_out = 6, dec_out = 8'h40.

Source files
------------

// File: rtl/min_codec_pkg.sv
// Shared types and helpers for the lowest-set-bit encoder / one-hot decoder pair.
package min_codec_pkg;

   // Default index width; the vector width is always 2**N.
   localparam int DefaultN = 3;
   localparam int DefaultW = 1 << DefaultN;

   typedef logic [DefaultN-1:0] index_t;
   typedef logic [DefaultW-1:0] vec_t;

   // Smallest r such that 2**r >= value; exact log2 for powers of two.
   function automatic int unsigned ceilLog2(input longint unsigned value);
      int unsigned result;
      result = 0;
      while ((64'd1 << result) < value) begin
         result++;
      end
      return result;
   endfunction

endpackage

// File: rtl/lsb_priority_encoder.sv
// Combinational lowest-set-bit priority encoder: bit 0 wins, all-zero flags none.
module lsb_priority_encoder
   import min_codec_pkg::*;
#(
   parameter int N = DefaultN,
   localparam int W = 1 << N
) (
   input  logic [W-1:0] vec,
   output logic [N-1:0] idx,
   output logic         none
);

   // Scan from the top bit down so the lowest set bit is the last one to write idx.
   always_comb begin
      idx  = '0;
      none = 1'b1;
      for (int i = W - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx  = N'(i);
            none = 1'b0;
         end
      end
   end

endmodule

// File: rtl/min_index_codec.sv
// Registered "minimum" encoder and its inverse one-hot decoder, one cycle of latency.
module min_index_codec
   import min_codec_pkg::*;
#(
   parameter int N = DefaultN,
   localparam int W = 1 << N
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] enc_in,
   output logic [N-1:0] enc_out,
   output logic         enc_none,
   input  logic [N-1:0] dec_in,
   output logic [W-1:0] dec_out
);

   logic [N-1:0] encOut_d;
   logic [N-1:0] encOut_q;
   logic         encNone_d;
   logic         encNone_q;
   logic [W-1:0] decOut_d;
   logic [W-1:0] decOut_q;

   lsb_priority_encoder #(
      .N(N)
   ) uEncoder (
      .vec (enc_in),
      .idx (encOut_d),
      .none(encNone_d)
   );

   // Every N-bit index is in range, so the decode is a plain shift.
   assign decOut_d = W'(1) << dec_in;

   // Output registers for both independent paths; reset forces the idle values.
   always_ff @(posedge clk) begin
      if (reset) begin
         encOut_q  <= '0;
         encNone_q <= 1'b1;
         decOut_q  <= '0;
      end else begin
         encOut_q  <= encOut_d;
         encNone_q <= encNone_d;
         decOut_q  <= decOut_d;
      end
   end

   assign enc_out  = encOut_q;
   assign enc_none = encNone_q;
   assign dec_out  = decOut_q;

endmodule

// File: tb/tb_min_index_codec.sv
// Self-checking bench for min_index_codec at N = 3, 1 and 5.
module tb_min_index_codec;
   import min_codec_pkg::*;

   logic clk = 1'b0;
   logic reset;
   logic loopMode;

   int vecCount  = 0;
   int missCount = 0;

   // N = 3 instance
   vec_t   encDrv3, encIn3, decOut3;
   index_t decIn3, encOut3;
   logic   encNone3;
   // N = 1 instance
   logic [1:0]  encDrv1, encIn1, decOut1;
   logic [0:0]  decIn1, encOut1;
   logic        encNone1;
   // N = 5 instance
   logic [31:0] encDrv5, encIn5, decOut5;
   logic [4:0]  decIn5, encOut5;
   logic        encNone5;

   // Expected outputs, produced by the model one edge before they are compared
   logic [63:0] expEnc3, expDec3, expEnc1, expDec1, expEnc5, expDec5;
   logic        expNone3, expNone1, expNone5;
   logic        expValid = 1'b0;

   always #5 clk = ~clk;

   // Round-trip mode feeds each decoder's output straight into its encoder.
   assign encIn3 = loopMode ? decOut3 : encDrv3;
   assign encIn1 = loopMode ? decOut1 : encDrv1;
   assign encIn5 = loopMode ? decOut5 : encDrv5;

   min_index_codec #(.N(3)) dut3 (
      .clk(clk), .reset(reset), .enc_in(encIn3), .enc_out(encOut3),
      .enc_none(encNone3), .dec_in(decIn3), .dec_out(decOut3)
   );

   min_index_codec #(.N(1)) dut1 (
      .clk(clk), .reset(reset), .enc_in(encIn1), .enc_out(encOut1),
      .enc_none(encNone1), .dec_in(decIn1), .dec_out(decOut1)
   );

   min_index_codec #(.N(5)) dut5 (
      .clk(clk), .reset(reset), .enc_in(encIn5), .enc_out(encOut5),
      .enc_none(encNone5), .dec_in(decIn5), .dec_out(decOut5)
   );

   // Lowest set bit: isolate it with v & -v, then take its exact log2.
   function automatic logic [63:0] modelIndex(input logic [63:0] v);
      logic [63:0] iso;
      if (v == 64'd0) return 64'd0;
      iso = v & (~v + 64'd1);
      return 64'(ceilLog2(iso));
   endfunction

   function automatic logic [63:0] modelOneHot(input int k);
      return 64'd1 << k;
   endfunction

   // Model: what each output must hold after this edge.
   always @(posedge clk) begin
      if (reset) begin
         expEnc3 <= 64'd0; expNone3 <= 1'b1; expDec3 <= 64'd0;
         expEnc1 <= 64'd0; expNone1 <= 1'b1; expDec1 <= 64'd0;
         expEnc5 <= 64'd0; expNone5 <= 1'b1; expDec5 <= 64'd0;
      end else begin
         expEnc3  <= modelIndex(64'(encIn3));
         expNone3 <= (encIn3 == '0);
         expDec3  <= modelOneHot(int'(decIn3));
         expEnc1  <= modelIndex(64'(encIn1));
         expNone1 <= (encIn1 == '0);
         expDec1  <= modelOneHot(int'(decIn1));
         expEnc5  <= modelIndex(64'(encIn5));
         expNone5 <= (encIn5 == '0);
         expDec5  <= modelOneHot(int'(decIn5));
      end
      expValid <= 1'b1;
   end

   task automatic checkOutput(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Compare every output against the model on each falling edge.
   always @(negedge clk) begin
      if (expValid) begin
         checkOutput("model enc_out N3",  64'(encOut3),  expEnc3);
         checkOutput("model enc_none N3", 64'(encNone3), 64'(expNone3));
         checkOutput("model dec_out N3",  64'(decOut3),  expDec3);
         checkOutput("model enc_out N1",  64'(encOut1),  expEnc1);
         checkOutput("model enc_none N1", 64'(encNone1), 64'(expNone1));
         checkOutput("model dec_out N1",  64'(decOut1),  expDec1);
         checkOutput("model enc_out N5",  64'(encOut5),  expEnc5);
         checkOutput("model enc_none N5", 64'(encNone5), 64'(expNone5));
         checkOutput("model dec_out N5",  64'(decOut5),  expDec5);
      end
   end

   // Drive the N = 3 inputs, then wait until the edge that captures them has passed.
   task automatic applyStimulus(input logic [7:0] enc, input logic [2:0] dec);
      encDrv3 = enc;
      decIn3  = dec;
      @(negedge clk);
      #1;
   endtask

   task automatic applyWide(input logic [31:0] enc5, input logic [4:0] dec5,
                            input logic [1:0] enc1, input logic dec1);
      encDrv5 = enc5;
      decIn5  = dec5;
      encDrv1 = enc1;
      decIn1  = dec1;
   endtask

   task automatic checkN3(input string name, input logic [2:0] enc,
                          input logic none, input logic [7:0] dec);
      checkOutput({name, " enc_out"},  64'(encOut3),  64'(enc));
      checkOutput({name, " enc_none"}, 64'(encNone3), 64'(none));
      checkOutput({name, " dec_out"},  64'(decOut3),  64'(dec));
   endtask

   logic [7:0] oneHotTbl [8];

   initial begin
      oneHotTbl = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
      reset    = 1'b1;
      loopMode = 1'b0;
      encDrv3  = 8'h00;
      decIn3   = 3'd0;
      applyWide(32'd0, 5'd0, 2'd0, 1'b0);
      @(negedge clk);
      #1;

      // Reset held for a second edge
      applyStimulus(8'h00, 3'd0);
      checkN3("reset", 3'd0, 1'b1, 8'h00);

      // Release with all-zero input
      reset = 1'b0;
      applyStimulus(8'h00, 3'd0);
      checkN3("first edge", 3'd0, 1'b1, 8'h01);

      applyStimulus(8'b1010_0000, 3'd1);
      checkN3("enc a0", 3'd5, 1'b0, 8'h02);
      applyStimulus(8'h80, 3'd2);
      checkN3("enc 80", 3'd7, 1'b0, 8'h04);
      applyStimulus(8'hFF, 3'd3);
      checkN3("enc ff", 3'd0, 1'b0, 8'h08);

      // Full encoder sweep with a reset pulse in the middle
      for (int i = 0; i < 256; i++) begin
         if (i == 100) begin
            reset = 1'b1;
            applyWide(32'h0001_0000, 5'd9, 2'b10, 1'b1);
            applyStimulus(8'h40, 3'd6);
            checkN3("mid reset", 3'd0, 1'b1, 8'h00);
            reset = 1'b0;
            applyStimulus(8'h40, 3'd6);
            checkN3("post reset", 3'd6, 1'b0, 8'h40);
            checkOutput("post reset enc_out N5", 64'(encOut5), 64'd16);
            checkOutput("post reset enc_out N1", 64'(encOut1), 64'd1);
         end
         applyWide({8'(i), 8'(255 - i), 8'(i * 7), 8'(i)}, 5'(i), 2'(i), 1'(i));
         applyStimulus(8'(i), 3'(i));
      end

      // Decoder sweep against a literal table
      for (int k = 0; k < 8; k++) begin
         applyStimulus(8'h01, 3'(k));
         checkOutput("dec sweep dec_out", 64'(decOut3), 64'(oneHotTbl[k]));
      end

      // Round trip: decoder output loops back into the encoder
      loopMode = 1'b1;
      for (int k = 0; k < 32; k++) begin
         applyWide(32'd0, 5'(k), 2'd0, 1'(k));
         applyStimulus(8'h00, 3'(k));
         applyStimulus(8'h00, 3'(k));
         checkOutput("loop enc_out N3",  64'(encOut3),  64'(k % 8));
         checkOutput("loop enc_none N3", 64'(encNone3), 64'd0);
         checkOutput("loop enc_out N1",  64'(encOut1),  64'(k % 2));
         checkOutput("loop enc_out N5",  64'(encOut5),  64'(k));
         checkOutput("loop enc_none N5", 64'(encNone5), 64'd0);
         if (k == 17) begin
            checkOutput("loop 17 dec_out N5", 64'(decOut5), 64'h0002_0000);
            checkOutput("loop 17 enc_out N5", 64'(encOut5), 64'd17);
         end
      end
      loopMode = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
